// File: rtl/dti_pack.sv
// Shared DTI definitions: opcodes, table sizing, AXIS widths and the ROB entry state type.
package dti_pack;

  localparam int TBU_NUM           = 64;
  localparam int TBU_NUM_WIDTH     = 6;
  localparam int CUSTOM_DATA_WIDTH = 80;
  localparam int CUSTOM_KEEP_WIDTH = CUSTOM_DATA_WIDTH / 8;

  localparam int AXIS_DATA_WIDTH   = CUSTOM_DATA_WIDTH;
  localparam int AXIS_KEEP_WIDTH   = CUSTOM_KEEP_WIDTH;
  localparam int AXIS_TID_WIDTH    = TBU_NUM_WIDTH;

  localparam logic [3:0] DTI_TBU_CONDIS_REQ = 4'h0;
  localparam logic [3:0] DTI_TBU_CONDIS_ACK = 4'h0;

  typedef enum logic [1:0] {
    ROB_IDLE       = 2'd0,
    ROB_CONNECTING = 2'd1,
    ROB_CONNECTED  = 2'd2,
    ROB_DISC_WAIT  = 2'd3
  } rob_state_e;

endpackage

// File: rtl/dti_pr_rob_entry.sv
// One DTI partial-reset table entry: tracks a TBU connection and emits teardown beats when granted.
// Optional simulation checks are enabled with DTI_PR_ENTRY_CHECK_EN.
module dti_pr_rob_entry #(
  parameter int TBU_NUM_WIDTH     = dti_pack::TBU_NUM_WIDTH,
  parameter int CUSTOM_DATA_WIDTH = dti_pack::CUSTOM_DATA_WIDTH,
  parameter int CUSTOM_KEEP_WIDTH = dti_pack::CUSTOM_KEEP_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         entry_alloc,
  input  logic                         entry_update,
  input  logic                         entry_ack_connected,
  input  logic                         entry_release,
  input  logic                         entry_reset,
  input  logic                         req_last,
  input  logic                         req_ready,
  input  logic [TBU_NUM_WIDTH-1:0]     entry_tid_in,
  output logic                         idle,
  output logic [TBU_NUM_WIDTH-1:0]     entry_tid_out,
  output logic                         entry_req_valid,
  output logic [CUSTOM_DATA_WIDTH-1:0] entry_req_data,
  output logic [CUSTOM_KEEP_WIDTH-1:0] entry_req_keep,
  output logic                         entry_req_last
);
  import dti_pack::*;

  rob_state_e                 state_q, state_d;
  logic                       mid_pkt_q, mid_pkt_d;
  logic [TBU_NUM_WIDTH-1:0]   tid_q, tid_d;
  logic                       beat_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ROB_IDLE;
      mid_pkt_q <= 1'b0;
      tid_q     <= '0;
    end else begin
      state_q   <= state_d;
      mid_pkt_q <= mid_pkt_d;
      tid_q     <= tid_d;
    end
  end

  // Teardown beats exist only while the partial-reset grant is held on a live connection.
  always_comb begin
    entry_req_valid = 1'b0;
    entry_req_data  = '0;
    entry_req_keep  = '0;
    entry_req_last  = 1'b0;
    if (entry_reset && (state_q == ROB_CONNECTED)) begin
      entry_req_valid = 1'b1;
      entry_req_last  = 1'b1;
      if (!mid_pkt_q) begin
        entry_req_data[3:0] = DTI_TBU_CONDIS_REQ;
        entry_req_data[4]   = 1'b0;
        entry_req_keep      = {{(CUSTOM_KEEP_WIDTH-4){1'b0}}, 4'hF};
      end
    end
  end

  assign beat_fire = entry_req_valid && req_ready;

  // Release outranks everything; a pending close beat must drain before the disconnect beat.
  always_comb begin
    state_d   = state_q;
    mid_pkt_d = mid_pkt_q;
    tid_d     = tid_q;
    if (entry_release && (state_q != ROB_IDLE)) begin
      state_d   = ROB_IDLE;
      mid_pkt_d = 1'b0;
    end else begin
      unique case (state_q)
        ROB_IDLE: begin
          if (entry_alloc) begin
            state_d   = ROB_CONNECTING;
            tid_d     = entry_tid_in;
            mid_pkt_d = !req_last;
          end
        end
        ROB_CONNECTING: begin
          if (entry_update && !entry_reset) mid_pkt_d = !req_last;
          if (entry_ack_connected) state_d = ROB_CONNECTED;
        end
        ROB_CONNECTED: begin
          if (beat_fire) begin
            if (mid_pkt_q) mid_pkt_d = 1'b0;
            else           state_d   = ROB_DISC_WAIT;
          end else if (entry_update && !entry_reset) begin
            mid_pkt_d = !req_last;
          end
        end
        ROB_DISC_WAIT: begin
        end
        default: state_d = ROB_IDLE;
      endcase
    end
  end

  assign idle          = (state_q == ROB_IDLE);
  assign entry_tid_out = tid_q;

`ifdef DTI_PR_ENTRY_CHECK_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cycle_cnt <= '0;
    else     cycle_cnt <= cycle_cnt + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (entry_alloc && (state_q != ROB_IDLE))
        $display("ENTRY_ERR cycle %0d: alloc while not idle", cycle_cnt);
      if ((entry_ack_connected || entry_release) && (state_q == ROB_IDLE))
        $display("ENTRY_ERR cycle %0d: ack/release while idle", cycle_cnt);
      if (entry_ack_connected && (state_q != ROB_CONNECTING))
        $display("ENTRY_ERR cycle %0d: ack_connected outside connecting", cycle_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_dti_pr_rob_entry.sv
// Scoreboard bench for dti_pr_rob_entry: directed lifecycle sequences then randomized traffic.
module tb_dti_pr_rob_entry;
  import dti_pack::*;

  localparam int TW = 6;
  localparam int DW = 80;
  localparam int KW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          entry_alloc = 1'b0, entry_update = 1'b0, entry_ack_connected = 1'b0;
  logic          entry_release = 1'b0, entry_reset = 1'b0, req_last = 1'b0, req_ready = 1'b0;
  logic [TW-1:0] entry_tid_in = '0;
  logic          idle;
  logic [TW-1:0] entry_tid_out;
  logic          entry_req_valid;
  logic [DW-1:0] entry_req_data;
  logic [KW-1:0] entry_req_keep;
  logic          entry_req_last;

  always #5 clk = ~clk;

  dti_pr_rob_entry #(
    .TBU_NUM_WIDTH    (TW),
    .CUSTOM_DATA_WIDTH(DW),
    .CUSTOM_KEEP_WIDTH(KW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .entry_alloc        (entry_alloc),
    .entry_update       (entry_update),
    .entry_ack_connected(entry_ack_connected),
    .entry_release      (entry_release),
    .entry_reset        (entry_reset),
    .req_last           (req_last),
    .req_ready          (req_ready),
    .entry_tid_in       (entry_tid_in),
    .idle               (idle),
    .entry_tid_out      (entry_tid_out),
    .entry_req_valid    (entry_req_valid),
    .entry_req_data     (entry_req_data),
    .entry_req_keep     (entry_req_keep),
    .entry_req_last     (entry_req_last)
  );

  typedef struct {
    logic          idle;
    logic [TW-1:0] tid;
    logic          valid;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pushed = 0;
  int   n_popped = 0;

  // Reference: a connection is open once allocated, live once acked, and finished once the disconnect beat went out.
  bit          m_active, m_acked, m_torn, m_open;
  logic [TW-1:0] m_tid;

  task automatic applyStimulus(input bit s_rst, input bit s_alloc, input bit s_update,
                               input bit s_ack, input bit s_rel, input bit s_reset,
                               input bit s_last, input bit s_ready, input logic [TW-1:0] s_tid);
    exp_t e;
    bit   beat;
    @(posedge clk);
    #1;
    rst                 = s_rst;
    entry_alloc         = s_alloc;
    entry_update        = s_update;
    entry_ack_connected = s_ack;
    entry_release       = s_rel;
    entry_reset         = s_reset;
    req_last            = s_last;
    req_ready           = s_ready;
    entry_tid_in        = s_tid;
    if (s_rst) begin
      m_active = 0; m_acked = 0; m_torn = 0; m_open = 0; m_tid = '0;
    end
    beat    = s_reset && m_active && m_acked && !m_torn;
    e.idle  = !m_active;
    e.tid   = m_tid;
    e.valid = beat;
    e.data  = '0;
    e.keep  = '0;
    e.last  = beat;
    if (beat && !m_open) begin
      e.data[3:0] = 4'h0;
      e.keep      = 10'h00F;
    end
    exp_q.push_back(e);
    n_pushed++;
    if (!s_rst) begin
      if (s_rel && m_active) begin
        m_active = 0; m_acked = 0; m_torn = 0; m_open = 0;
      end else if (!m_active) begin
        if (s_alloc) begin
          m_active = 1; m_acked = 0; m_torn = 0;
          m_tid    = s_tid;
          m_open   = !s_last;
        end
      end else begin
        if (beat && s_ready) begin
          if (m_open) m_open = 0;
          else        m_torn = 1;
        end else if (s_update && !s_reset && !m_torn) begin
          m_open = !s_last;
        end
        if (s_ack && !m_acked) m_acked = 1;
      end
    end
  endtask

  task automatic checkOutput(input exp_t e);
    n_checks++;
    if (idle !== e.idle || entry_tid_out !== e.tid || entry_req_valid !== e.valid ||
        entry_req_data !== e.data || entry_req_keep !== e.keep || entry_req_last !== e.last) begin
      n_fail++;
      $display("[TB] FAIL entry_out @%0t: got idle=%b tid=%h valid=%b data=%h keep=%h last=%b, want idle=%b tid=%h valid=%b data=%h keep=%h last=%b",
               $time, idle, entry_tid_out, entry_req_valid, entry_req_data, entry_req_keep, entry_req_last,
               e.idle, e.tid, e.valid, e.data, e.keep, e.last);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      n_popped++;
      checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // args: rst, alloc, update, ack, rel, reset, last, ready, tid
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 6'h00);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 6'h15);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 6'h00);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 6'h00);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 6'h00);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 6'h00);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 6'h00);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 6'h00);

    applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 6'h2A);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 6'h00);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 6'h00);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 6'h00);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 6'h00);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 6'h00);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 6'h00);

    applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 6'h07);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 6'h00);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 1, 6'h00);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 6'h00);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 6'h00);

    applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 6'h3C);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 6'h00);
    applyStimulus(0, 0, 0, 1, 0, 1, 0, 1, 6'h00);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 6'h00);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 6'h00);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, 6'h00);

    applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 6'h11);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 6'h00);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 6'h00);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 1, 6'h00);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 6'h00);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(99) == 0, $urandom_range(3) == 0, $urandom_range(2) == 0,
                    $urandom_range(5) == 0, $urandom_range(9) == 0, $urandom_range(2) == 0,
                    $urandom_range(1) == 0, $urandom_range(1) == 0, TW'($urandom));
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0 || n_popped != n_pushed) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got popped=%0d left=%0d, want popped=%0d left=0",
               n_popped, exp_q.size(), n_pushed);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
